// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and the request error check for the LSU.
package lsu_pkg;

    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MERGE = 2'b01,
        RESP  = 2'b10
    } lsu_state_t;

    // A request is rejected for an illegal size, a misaligned half/word,
    // or a byte address at or beyond the end of dmem (limit is in bytes).
    function automatic logic lsu_req_err(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [32:0] limit);
        logic err;
        err = 1'b0;
        if (size == 2'b11)                          err = 1'b1;
        if (size == LSU_H && addr[0])               err = 1'b1;
        if (size == LSU_W && addr[1:0] != 2'b00)    err = 1'b1;
        if ({1'b0, addr} >= limit)                  err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational lane handling: load extraction/extension and store merge.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;

    // Pick the addressed lane out of the word and sign/zero-extend it.
    always_comb begin
        byte_sel  = word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        byte_s    = byte_sel;
        half_s    = half_sel;
        byte_ext  = byte_s;
        half_ext  = half_s;
        load_data = '0;
        case (size)
            LSU_B:   load_data = is_unsigned ? {24'b0, byte_sel} : byte_ext;
            LSU_H:   load_data = is_unsigned ? {16'b0, half_sel} : half_ext;
            LSU_W:   load_data = word;
            default: load_data = '0;
        endcase
    end

    // Insert the new byte/half into the old word, keeping the other bytes.
    always_comb begin
        merged = word;
        case (size)
            LSU_B:   merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            LSU_H:   begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            LSU_W:   merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: word-only dmem access, load extension, RMW stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dmem_enable,
    output logic        dmem_rnw,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    lsu_state_t  state, state_next;
    logic        accept;
    logic        req_err;
    logic        word_store;
    logic        sub_store;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [31:0] merge_word;
    logic [31:0] merge_addr;

    assign accept     = req_valid && req_ready;
    assign req_err    = lsu_req_err(req_size, req_addr, ADDR_LIMIT);
    assign word_store = req_wen && (req_size == LSU_W);
    assign sub_store  = req_wen && (req_size != LSU_W);

    lsu_lane_fmt u_lane_fmt (
        .word        (dmem_rdata),
        .wdata       (req_wdata),
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .load_data   (load_data),
        .merged      (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, handshake and dmem drive; reset suppresses any access.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        dmem_enable = 1'b0;
        dmem_rnw    = 1'b1;
        dmem_addr   = {req_addr[31:2], 2'b00};
        dmem_wdata  = req_wdata;
        if (!reset) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (req_err) begin
                            state_next = RESP;
                        end else begin
                            dmem_enable = 1'b1;
                            dmem_rnw    = !word_store;
                            state_next  = sub_store ? MERGE : RESP;
                        end
                    end
                end
                MERGE: begin
                    dmem_enable = 1'b1;
                    dmem_rnw    = 1'b0;
                    dmem_addr   = merge_addr;
                    dmem_wdata  = merge_word;
                    state_next  = RESP;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Response registers, captured on accept and held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == IDLE && accept) begin
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || req_wen) ? 32'h0 : load_data;
        end
    end

    // Merged word and aligned address for the write half of a sub-word store.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && sub_store && !req_err) begin
            merge_word <= merged;
            merge_addr <= {req_addr[31:2], 2'b00};
        end
    end

endmodule
